// File: rtl/hack_dmem_map_pkg.sv
// Shared constants and address-decode helper for the Hack data-memory map.
// Imported by the map top and its testbench-facing interface users.
package hack_dmem_map_pkg;

  localparam int DMEM_ADDR_W = 15;
  localparam int SCR_AW      = 13;
  localparam int RAM_AW      = 14;
  localparam int RAM_WORDS   = 1 << RAM_AW;
  localparam int SCR_WORDS   = 1 << SCR_AW;

  localparam logic [DMEM_ADDR_W-1:0] SCREEN_BASE = 15'h4000;
  localparam logic [DMEM_ADDR_W-1:0] KBD_ADDR    = 15'h6000;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_SCR  = 2'd1,
    REG_KBD  = 2'd2,
    REG_NONE = 2'd3
  } region_e;

  // Everything above the keyboard word is unmapped: reads 0, writes dropped.
  function automatic region_e decode_region(input logic [DMEM_ADDR_W-1:0] addr);
    if (addr < SCREEN_BASE)   return REG_RAM;
    else if (addr < KBD_ADDR) return REG_SCR;
    else if (addr == KBD_ADDR) return REG_KBD;
    else                      return REG_NONE;
  endfunction

endpackage

// File: rtl/hack_dmem_map_if.sv
// CPU data port, keyboard input and screen-write stream of the Hack memory map.
// Stream handshake: a word transfers on any rising edge where scr_valid_o and
// scr_ready_i are both 1; while valid is high and ready low, address/data hold.
interface hack_dmem_map_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int DROP_W = 8
);
  logic [ADDR_W-1:0] dmem_addr_i;
  logic [DATA_W-1:0] dmem_data_i;
  logic              dmem_wr_en_i;
  logic [DATA_W-1:0] dmem_data_o;
  logic              kbd_valid_i;
  logic [DATA_W-1:0] kbd_code_i;
  logic              scr_valid_o;
  logic              scr_ready_i;
  logic [12:0]       scr_addr_o;
  logic [DATA_W-1:0] scr_data_o;
  logic              scr_overflow_o;
  logic [DROP_W-1:0] scr_drop_cnt_o;

  modport slave (
    input  dmem_addr_i, dmem_data_i, dmem_wr_en_i, kbd_valid_i, kbd_code_i, scr_ready_i,
    output dmem_data_o, scr_valid_o, scr_addr_o, scr_data_o, scr_overflow_o, scr_drop_cnt_o
  );

  modport master (
    output dmem_addr_i, dmem_data_i, dmem_wr_en_i, kbd_valid_i, kbd_code_i, scr_ready_i,
    input  dmem_data_o, scr_valid_o, scr_addr_o, scr_data_o, scr_overflow_o, scr_drop_cnt_o
  );
endinterface

// File: rtl/hack_scr_fifo.sv
// First-word fall-through FIFO for screen writes; head word is shown as soon as
// it is written. A push while full succeeds only if a pop happens that cycle.
module hack_scr_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hack_dmem_map.sv
// Hack data-memory map: 16K RAM, 8K screen shadow, keyboard register, and a
// screen-write stream with overflow accounting. Reads are combinational.
module hack_dmem_map
  import hack_dmem_map_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  hack_dmem_map_if.slave   bus
);
  logic [DATA_W-1:0]        r_ram [RAM_WORDS];
  logic [DATA_W-1:0]        r_scr [SCR_WORDS];
  logic [DATA_W-1:0]        r_kbd;
  logic                     r_overflow;
  logic [DROP_W-1:0]        r_drop_cnt;

  logic [ADDR_W-1:0]        w_addr;
  region_e                  w_region;
  logic [SCR_AW-1:0]        w_scr_off;
  logic [DATA_W-1:0]        w_rdata;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_drop;
  logic                     w_full;
  logic                     w_empty;
  logic [SCR_AW+DATA_W-1:0] w_fifo_rdata;

  assign w_addr    = bus.dmem_addr_i;
  assign w_region  = decode_region(w_addr);
  // Screen base is 8K-aligned, so the low bits are already the word offset.
  assign w_scr_off = w_addr[SCR_AW-1:0];

  always_comb begin
    w_rdata = '0;
    case (w_region)
      REG_RAM: w_rdata = r_ram[w_addr[RAM_AW-1:0]];
      REG_SCR: w_rdata = r_scr[w_scr_off];
      REG_KBD: w_rdata = r_kbd;
      default: w_rdata = '0;
    endcase
  end
  assign bus.dmem_data_o = w_rdata;

  // Storage is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (bus.dmem_wr_en_i && (w_region == REG_RAM)) r_ram[w_addr[RAM_AW-1:0]] <= bus.dmem_data_i;
    if (bus.dmem_wr_en_i && (w_region == REG_SCR)) r_scr[w_scr_off] <= bus.dmem_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)           r_kbd <= '0;
    else if (bus.kbd_valid_i) r_kbd <= bus.kbd_code_i;
  end

  assign w_push = bus.dmem_wr_en_i && (w_region == REG_SCR);
  assign w_pop  = !w_empty && bus.scr_ready_i;
  assign w_drop = w_push && w_full && !w_pop;

  hack_scr_fifo #(
    .WIDTH (SCR_AW + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (reset_n_i),
    .i_push  (w_push),
    .i_wdata ({w_scr_off, bus.dmem_data_i}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.scr_valid_o = !w_empty;
  assign {bus.scr_addr_o, bus.scr_data_o} = w_fifo_rdata;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
    end
  end

  assign bus.scr_overflow_o = r_overflow;
  assign bus.scr_drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_hack_dmem_map.sv
// Bench for hack_dmem_map: directed vector table, hand sequences for overflow,
// saturation and mid-stream reset, then random traffic against a queue model.
module tb_hack_dmem_map;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hack_dmem_map_if #(.DATA_W(16), .ADDR_W(15), .DROP_W(8)) bus ();

  hack_dmem_map #(
    .DATA_W(16), .ADDR_W(15), .FIFO_DEPTH(DEPTH), .DROP_W(8)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
    logic        we;
    logic        kv;
    logic [15:0] kc;
    logic        rdy;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic        exp_v;
    logic [12:0] exp_sa;
    logic [15:0] exp_sd;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: memory maps, keyboard word, stream queue, drop stats.
  logic [15:0] ram_m [int];
  logic [15:0] scr_m [int];
  logic [15:0] kbd_m;
  logic [28:0] exp_q [$];
  logic        ovf_m;
  int          drop_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkt(input logic [14:0] addr, input logic [15:0] data, input logic we,
                               input logic kv, input logic [15:0] kc, input logic rdy,
                               input logic chk_rd, input logic [15:0] exp_rd, input logic exp_v,
                               input logic [12:0] exp_sa, input logic [15:0] exp_sd);
    vec_t v;
    v.addr = addr; v.data = data; v.we = we; v.kv = kv; v.kc = kc; v.rdy = rdy;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_v = exp_v; v.exp_sa = exp_sa; v.exp_sd = exp_sd;
    return v;
  endfunction

  function automatic vec_t mk(input logic [14:0] addr, input logic [15:0] data, input logic we,
                              input logic kv, input logic [15:0] kc, input logic rdy);
    return mkt(addr, data, we, kv, kc, rdy, 1'b0, 16'h0, 1'b0, 13'h0, 16'h0);
  endfunction

  task automatic model_check(input logic [14:0] a_in);
    int a;
    a = int'(a_in);
    if (a < 'h4000) begin
      if (ram_m.exists(a)) chk("rd_ram", 32'(bus.dmem_data_o), 32'(ram_m[a]));
    end else if (a < 'h6000) begin
      if (scr_m.exists(a - 'h4000)) chk("rd_scr", 32'(bus.dmem_data_o), 32'(scr_m[a - 'h4000]));
    end else if (a == 'h6000) begin
      chk("rd_kbd", 32'(bus.dmem_data_o), 32'(kbd_m));
    end else begin
      chk("rd_unmapped", 32'(bus.dmem_data_o), 32'h0);
    end
    chk("scr_valid", 32'(bus.scr_valid_o), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("scr_entry", 32'({bus.scr_addr_o, bus.scr_data_o}), 32'(exp_q[0]));
    else                  chk("scr_idle", 32'({bus.scr_addr_o, bus.scr_data_o}), 32'h0);
    chk("overflow", 32'(bus.scr_overflow_o), 32'(ovf_m));
    chk("drop_cnt", 32'(bus.scr_drop_cnt_o), 32'(drop_m));
  endtask

  task automatic model_update(input vec_t v);
    int a;
    bit pop;
    bit acc;
    a   = int'(v.addr);
    pop = (exp_q.size() > 0) && v.rdy;
    acc = 1'b0;
    if (v.we && a < 'h4000) ram_m[a] = v.data;
    if (v.we && a >= 'h4000 && a < 'h6000) begin
      scr_m[a - 'h4000] = v.data;
      acc = (exp_q.size() < DEPTH) || pop;
      if (!acc) begin
        ovf_m = 1'b1;
        if (drop_m < 255) drop_m++;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back({13'(a - 'h4000), v.data});
    if (v.kv) kbd_m = v.kc;
  endtask

  task automatic step(input vec_t v, input bit use_tab);
    bus.dmem_addr_i  = v.addr;
    bus.dmem_data_i  = v.data;
    bus.dmem_wr_en_i = v.we;
    bus.kbd_valid_i  = v.kv;
    bus.kbd_code_i   = v.kc;
    bus.scr_ready_i  = v.rdy;
    @(negedge clk);
    model_check(v.addr);
    if (use_tab) begin
      if (v.chk_rd) chk("tab_rd", 32'(bus.dmem_data_o), 32'(v.exp_rd));
      chk("tab_valid", 32'(bus.scr_valid_o), 32'(v.exp_v));
      chk("tab_saddr", 32'(bus.scr_addr_o), 32'(v.exp_sa));
      chk("tab_sdata", 32'(bus.scr_data_o), 32'(v.exp_sd));
    end
    @(posedge clk);
    model_update(v);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [$];
    logic [28:0] drain_exp [$];
    int          got;

    rst_n = 1'b0;
    bus.dmem_addr_i  = 15'h6000;
    bus.dmem_data_i  = '0;
    bus.dmem_wr_en_i = 1'b0;
    bus.kbd_valid_i  = 1'b0;
    bus.kbd_code_i   = '0;
    bus.scr_ready_i  = 1'b0;
    kbd_m = '0; ovf_m = 1'b0; drop_m = 0;

    #12;
    chk("reset_valid", 32'(bus.scr_valid_o), 32'h0);
    chk("reset_ovf", 32'(bus.scr_overflow_o), 32'h0);
    chk("reset_drop", 32'(bus.scr_drop_cnt_o), 32'h0);
    chk("reset_saddr", 32'(bus.scr_addr_o), 32'h0);
    chk("reset_sdata", 32'(bus.scr_data_o), 32'h0);
    chk("reset_kbd", 32'(bus.dmem_data_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addr, data, we, kv, kc, rdy, chk_rd, exp_rd, exp_v, exp_sa, exp_sd
    vecs.push_back(mkt(15'h0010, 16'h1111, 1, 0, 16'h0,    1, 0, 16'h0,    0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h0010, 16'h1234, 1, 0, 16'h0,    1, 1, 16'h1111, 0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h0010, 16'h0,    0, 0, 16'h0,    1, 1, 16'h1234, 0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h4005, 16'hBEEF, 1, 0, 16'h0,    1, 0, 16'h0,    0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h4005, 16'h0,    0, 0, 16'h0,    1, 1, 16'hBEEF, 1, 13'h0005, 16'hBEEF));
    vecs.push_back(mkt(15'h4005, 16'h0,    0, 0, 16'h0,    1, 1, 16'hBEEF, 0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h6000, 16'h0,    0, 1, 16'h0041, 1, 1, 16'h0,    0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h6000, 16'hFFFF, 1, 0, 16'h0,    1, 1, 16'h0041, 0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h6000, 16'h0,    0, 0, 16'h0,    1, 1, 16'h0041, 0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h6000, 16'hFFFF, 1, 1, 16'h0052, 1, 1, 16'h0041, 0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h6000, 16'h0,    0, 0, 16'h0,    1, 1, 16'h0052, 0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h6001, 16'h0,    0, 0, 16'h0,    1, 1, 16'h0,    0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h3000, 16'h0AAA, 1, 0, 16'h0,    1, 0, 16'h0,    0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h7000, 16'h5555, 1, 0, 16'h0,    1, 1, 16'h0,    0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h7000, 16'h0,    0, 0, 16'h0,    1, 1, 16'h0,    0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h3000, 16'h0,    0, 0, 16'h0,    1, 1, 16'h0AAA, 0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h5FFF, 16'hCAFE, 1, 0, 16'h0,    1, 0, 16'h0,    0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h5FFF, 16'h0,    0, 0, 16'h0,    1, 1, 16'hCAFE, 1, 13'h1FFF, 16'hCAFE));
    vecs.push_back(mkt(15'h3FFF, 16'h0F0F, 1, 0, 16'h0,    1, 0, 16'h0,    0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h3FFF, 16'h0,    0, 0, 16'h0,    1, 1, 16'h0F0F, 0, 13'h0,    16'h0));
    vecs.push_back(mkt(15'h0010, 16'h0,    0, 0, 16'h0,    1, 1, 16'h1234, 0, 13'h0,    16'h0));
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], 1'b1);

    // Overflow: ten writes with the consumer stalled, eight must be kept.
    for (int i = 0; i < 10; i++) step(mk(15'(32'h4000 + i), 16'(32'hA000 + i), 1, 0, 16'h0, 0), 1'b0);
    chk("ovf_flag", 32'(bus.scr_overflow_o), 32'h1);
    chk("ovf_drop", 32'(bus.scr_drop_cnt_o), 32'h2);
    chk("ovf_head", 32'({bus.scr_addr_o, bus.scr_data_o}), 32'({13'h0, 16'hA000}));

    // Full FIFO, push and pop together: push accepted, no new drop.
    step(mk(15'h4100, 16'hB000, 1, 0, 16'h0, 1), 1'b0);
    chk("fullpop_drop", 32'(bus.scr_drop_cnt_o), 32'h2);
    for (int i = 1; i < 8; i++) drain_exp.push_back({13'(i), 16'(32'hA000 + i)});
    drain_exp.push_back({13'h100, 16'hB000});
    got = 0;
    for (int k = 0; k < 20 && bus.scr_valid_o; k++) begin
      chk("drain_entry", 32'({bus.scr_addr_o, bus.scr_data_o}), got < 8 ? 32'(drain_exp[got]) : 32'h0);
      got++;
      step(mk(15'h0010, 16'h0, 0, 0, 16'h0, 1), 1'b0);
    end
    chk("drain_count", 32'(got), 32'd8);

    // Drop counter saturation.
    for (int i = 0; i < 268; i++) step(mk(15'(32'h4000 + (i % 64)), 16'(i), 1, 0, 16'h0, 0), 1'b0);
    chk("drop_sat", 32'(bus.scr_drop_cnt_o), 32'd255);
    for (int k = 0; k < 12; k++) step(mk(15'h0010, 16'h0, 0, 0, 16'h0, 1), 1'b0);
    chk("drain_empty", 32'(bus.scr_valid_o), 32'h0);

    // Mid-stream asynchronous reset with three entries queued.
    step(mk(15'h0010, 16'h1234, 1, 0, 16'h0, 1), 1'b0);
    step(mk(15'h6000, 16'h0, 0, 1, 16'h0077, 0), 1'b0);
    for (int i = 0; i < 3; i++) step(mk(15'(32'h4010 + i), 16'(32'hC000 + i), 1, 0, 16'h0, 0), 1'b0);
    chk("pre_rst_valid", 32'(bus.scr_valid_o), 32'h1);
    bus.dmem_addr_i  = 15'h6000;
    bus.dmem_wr_en_i = 1'b0;
    bus.kbd_valid_i  = 1'b0;
    bus.scr_ready_i  = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    ovf_m = 1'b0; drop_m = 0; kbd_m = '0;
    #1;
    chk("rst_valid", 32'(bus.scr_valid_o), 32'h0);
    chk("rst_drop", 32'(bus.scr_drop_cnt_o), 32'h0);
    chk("rst_ovf", 32'(bus.scr_overflow_o), 32'h0);
    chk("rst_kbd", 32'(bus.dmem_data_o), 32'h0);
    chk("rst_saddr", 32'(bus.scr_addr_o), 32'h0);
    chk("rst_sdata", 32'(bus.scr_data_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(mkt(15'h0010, 16'h0, 0, 0, 16'h0, 1, 1, 16'h1234, 0, 13'h0, 16'h0), 1'b1);

    // Random traffic across all regions, checked against the model.
    for (int n = 0; n < 600; n++) begin
      int          sel;
      logic [14:0] a;
      sel = int'($urandom_range(0, 9));
      if (sel <= 2)      a = 15'($urandom_range(0, 31));
      else if (sel == 3) a = 15'h3FFF;
      else if (sel <= 5) a = 15'(32'h4000 + $urandom_range(0, 31));
      else if (sel == 6) a = 15'h5FFF;
      else if (sel == 7) a = 15'h6000;
      else if (sel == 8) a = 15'($urandom_range(32'h6001, 32'h7FFF));
      else               a = 15'($urandom_range(0, 32'h3FFF));
      step(mk(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
              16'($urandom), 1'($urandom_range(0, 3) != 0)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
